// File: rtl/tb_stream_checker.sv
// Clocked stream scoreboard: queued expectations with per-entry compare mode, pass/fail counters and watchdog.
// Optional TB_STREAM_CHECKER_DISPLAY_EN adds per-result $display lines (simulation only).
module tb_stream_checker #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TOL_W   = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [2:0]        exp_mode,
    input  logic [TOL_W-1:0]  exp_tol,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [DATA_W-1:0] act_data,
    output logic              res_valid,
    output logic              res_pass,
    output logic              res_timeout,
    output logic [DATA_W-1:0] res_actual,
    output logic [DATA_W-1:0] res_expected,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              any_fail,
    output logic              idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CMP_W = (DATA_W + 1 > TOL_W) ? DATA_W + 1 : TOL_W;
    localparam logic            WD_EN   = (TIMEOUT != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PTR_W:0]  FULL_C  = (PTR_W + 1)'(DEPTH);

    localparam logic [2:0] MODE_EQ = 3'd0, MODE_NE = 3'd1, MODE_LE = 3'd2, MODE_LT = 3'd3;
    localparam logic [2:0] MODE_GE = 3'd4, MODE_GT = 3'd5, MODE_NEAR = 3'd6, MODE_ANY = 3'd7;

    // Unsigned compare of actual against expected under the entry's mode.
    function automatic logic compare(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e,
                                     input logic [2:0] mode, input logic [TOL_W-1:0] tol);
        logic [DATA_W:0]  diff;
        logic [CMP_W-1:0] diff_w;
        logic [CMP_W-1:0] tol_w;
        diff   = (a >= e) ? ({1'b0, a} - {1'b0, e}) : ({1'b0, e} - {1'b0, a});
        diff_w = CMP_W'(diff);
        tol_w  = CMP_W'(tol);
        case (mode)
            MODE_EQ:   compare = (a == e);
            MODE_NE:   compare = (a != e);
            MODE_LE:   compare = (a <= e);
            MODE_LT:   compare = (a < e);
            MODE_GE:   compare = (a >= e);
            MODE_GT:   compare = (a > e);
            MODE_NEAR: compare = (diff_w <= tol_w);
            MODE_ANY:  compare = 1'b1;
            default:   compare = 1'b0;
        endcase
    endfunction

    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [2:0]        mode_mem_r [DEPTH];
    logic [TOL_W-1:0]  tol_mem_r  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [WD_W-1:0]   wd_r;

    logic              push_s, act_pop_s, fire_s, pop_s, cmp_pass_s;
    logic [DATA_W-1:0] head_data_s;
    logic [2:0]        head_mode_s;
    logic [TOL_W-1:0]  head_tol_s;

    // Handshakes, head view and watchdog expiry; readies depend on occupancy only.
    always_comb begin
        exp_ready   = (count_r < FULL_C);
        act_ready   = (count_r != {(PTR_W + 1){1'b0}});
        idle        = (count_r == {(PTR_W + 1){1'b0}});
        push_s      = exp_valid && exp_ready;
        act_pop_s   = act_valid && act_ready;
        head_data_s = data_mem_r[rd_ptr_r];
        head_mode_s = mode_mem_r[rd_ptr_r];
        head_tol_s  = tol_mem_r[rd_ptr_r];
        fire_s      = WD_EN && act_ready && !act_pop_s && (wd_r == WD_LAST);
        pop_s       = act_pop_s || fire_s;
        cmp_pass_s  = compare(act_data, head_data_s, head_mode_s, head_tol_s);
    end

    // Queue storage; contents beyond the occupancy are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= exp_data;
            mode_mem_r[wr_ptr_r] <= exp_mode;
            tol_mem_r[wr_ptr_r]  <= exp_tol;
        end
    end

    // Pointers, occupancy and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            wd_r     <= {WD_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s || idle || !WD_EN) wd_r <= {WD_W{1'b0}};
            else                         wd_r <= wd_r + WD_W'(1);
        end
    end

    // Registered result strobe, saturating counters and sticky fail flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_pass     <= 1'b0;
            res_timeout  <= 1'b0;
            res_actual   <= {DATA_W{1'b0}};
            res_expected <= {DATA_W{1'b0}};
            pass_count   <= {CNT_W{1'b0}};
            fail_count   <= {CNT_W{1'b0}};
            any_fail     <= 1'b0;
        end else begin
            res_valid   <= pop_s;
            res_pass    <= act_pop_s && cmp_pass_s;
            res_timeout <= fire_s;
            if (pop_s) begin
                res_actual   <= act_pop_s ? act_data : {DATA_W{1'b0}};
                res_expected <= head_data_s;
                if (act_pop_s && cmp_pass_s) begin
                    if (pass_count != {CNT_W{1'b1}}) pass_count <= pass_count + CNT_W'(1);
                end else begin
                    if (fail_count != {CNT_W{1'b1}}) fail_count <= fail_count + CNT_W'(1);
                    any_fail <= 1'b1;
                end
            end
        end
    end

`ifdef TB_STREAM_CHECKER_DISPLAY_EN
    logic [2:0] res_mode_r;

    function automatic string mode_name(input logic [2:0] m);
        case (m)
            MODE_EQ:   mode_name = "EQ";
            MODE_NE:   mode_name = "NE";
            MODE_LE:   mode_name = "LE";
            MODE_LT:   mode_name = "LT";
            MODE_GE:   mode_name = "GE";
            MODE_GT:   mode_name = "GT";
            MODE_NEAR: mode_name = "NEAR";
            default:   mode_name = "ANY";
        endcase
    endfunction

    // Mode of the entry behind the current result, kept only for the printout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        res_mode_r <= 3'd0;
        else if (pop_s) res_mode_r <= head_mode_s;
    end

    // One line per result strobe.
    always @(posedge clk) begin
        if (!rst && res_valid) begin
            if (res_timeout)
                $display("![FAIL] timeout exp=0x%0h", res_expected);
            else if (res_pass)
                $display(" [PASS] %s act=0x%0h exp=0x%0h", mode_name(res_mode_r), res_actual, res_expected);
            else
                $display("![FAIL] %s act=0x%0h exp=0x%0h", mode_name(res_mode_r), res_actual, res_expected);
        end
    end
`endif

endmodule

// File: tb/tb_tb_stream_checker.sv
// Bench for tb_stream_checker: queue-level reference model feeds a result scoreboard drained by a monitor.
module tb_tb_stream_checker;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_valid = 1'b0, act_valid = 1'b0;
    logic [31:0] exp_data = 32'd0, act_data = 32'd0;
    logic [2:0]  exp_mode = 3'd0;
    logic [7:0]  exp_tol = 8'd0;
    logic        exp_ready, act_ready, res_valid, res_pass, res_timeout, any_fail, idle;
    logic [31:0] res_actual, res_expected;
    logic [15:0] pass_count, fail_count;

    tb_stream_checker #(.DATA_W(32), .DEPTH(DEPTH), .TOL_W(8), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data), .exp_mode(exp_mode), .exp_tol(exp_tol),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .res_valid(res_valid), .res_pass(res_pass), .res_timeout(res_timeout),
        .res_actual(res_actual), .res_expected(res_expected),
        .pass_count(pass_count), .fail_count(fail_count), .any_fail(any_fail), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  mode;
        logic [7:0]  tol;
    } entry_t;

    typedef struct {
        bit          pass;
        bit          timeout;
        logic [31:0] actual;
        logic [31:0] expected;
        int          pass_cnt;
        int          fail_cnt;
        bit          any_fail;
        int          due;
    } result_t;

    entry_t  model_q[$];
    result_t sb[$];
    int      tb_cyc = 0;
    int      head_since = 0;
    int      pass_m = 0, fail_m = 0;
    bit      any_fail_m = 1'b0;
    int      checks = 0, errors = 0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, tb_cyc);
        end
    endtask

    function automatic bit ref_cmp(input longint unsigned a, input longint unsigned e,
                                   input logic [2:0] mode, input longint unsigned tol);
        longint unsigned d;
        d = (a > e) ? a - e : e - a;
        case (mode)
            3'd0: return a == e;
            3'd1: return a != e;
            3'd2: return a <= e;
            3'd3: return a < e;
            3'd4: return a >= e;
            3'd5: return a > e;
            3'd6: return d <= tol;
            default: return 1'b1;
        endcase
    endfunction

    // One clock of stimulus: check readiness, drive inputs, advance the queue model.
    task automatic cycle(input bit ev, input logic [31:0] ed, input logic [2:0] em, input logic [7:0] et,
                         input bit av, input logic [31:0] ad);
        bit      was_empty, push_m, pop_m, fire_m;
        entry_t  h;
        result_t r;
        @(negedge clk);
        chk("exp_ready", exp_ready, model_q.size() < DEPTH);
        chk("act_ready", act_ready, model_q.size() > 0);
        chk("idle", idle, model_q.size() == 0);
        exp_valid = ev; exp_data = ed; exp_mode = em; exp_tol = et;
        act_valid = av; act_data = ad;
        was_empty = (model_q.size() == 0);
        push_m = ev && (model_q.size() < DEPTH);
        pop_m  = av && !was_empty;
        fire_m = !was_empty && !pop_m && (tb_cyc - head_since == TIMEOUT - 1);
        if (pop_m || fire_m) begin
            h = model_q.pop_front();
            r.timeout  = fire_m;
            r.pass     = pop_m && ref_cmp(ad, h.data, h.mode, h.tol);
            r.actual   = pop_m ? ad : 32'd0;
            r.expected = h.data;
            if (r.pass) begin
                if (pass_m < (1 << CNT_W) - 1) pass_m++;
            end else begin
                if (fail_m < (1 << CNT_W) - 1) fail_m++;
                any_fail_m = 1'b1;
            end
            r.pass_cnt = pass_m;
            r.fail_cnt = fail_m;
            r.any_fail = any_fail_m;
            r.due      = tb_cyc + 1;
            sb.push_back(r);
        end
        if (push_m) model_q.push_back('{data: ed, mode: em, tol: et});
        if (was_empty || pop_m || fire_m) head_since = tb_cyc + 1;
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 32'd0);
    endtask

    // Scoreboard monitor: every result strobe must match the oldest predicted result, on time.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    result_t r;
                    r = sb.pop_front();
                    chk("res_latency", tb_cyc, r.due);
                    chk("res_pass", res_pass, r.pass);
                    chk("res_timeout", res_timeout, r.timeout);
                    chk("res_actual", res_actual, r.actual);
                    chk("res_expected", res_expected, r.expected);
                    chk("pass_count", pass_count, r.pass_cnt);
                    chk("fail_count", fail_count, r.fail_cnt);
                    chk("any_fail", any_fail, r.any_fail);
                end
            end else if (sb.size() > 0 && sb[0].due <= tb_cyc) begin
                chk("missing_res_valid", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_exp_ready", exp_ready, 1);
        chk("rst_act_ready", act_ready, 0);
        chk("rst_idle", idle, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_pass", res_pass, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_res_actual", res_actual, 0);
        chk("rst_res_expected", res_expected, 0);
        chk("rst_pass_count", pass_count, 0);
        chk("rst_fail_count", fail_count, 0);
        chk("rst_any_fail", any_fail, 0);
    endtask

    // Assert reset between edges, discarding the model state and any pending predicted result.
    task automatic apply_reset();
        #1;
        rst = 1'b1;
        exp_valid = 1'b0; act_valid = 1'b0;
        model_q.delete(); sb.delete();
        pass_m = 0; fail_m = 0; any_fail_m = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // EQ pass
        cycle(1'b1, 32'h5A, 3'd0, 8'd0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 32'h5A);
        idle_cycles(2);

        // LT 10, GE 10, NEAR 100 tol 3 against 9, 10, 104
        cycle(1'b1, 32'd10, 3'd3, 8'd0, 1'b0, 32'd0);
        cycle(1'b1, 32'd10, 3'd4, 8'd0, 1'b0, 32'd0);
        cycle(1'b1, 32'd100, 3'd6, 8'd3, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 32'd9);
        cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 32'd10);
        cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 32'd104);
        idle_cycles(2);

        // Fill to DEPTH, then push+pop while full (push refused), drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 3'd7, 8'd0, 1'b0, 32'd0);
        cycle(1'b1, 32'hDEAD, 3'd0, 8'd0, 1'b1, 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 32'(i + 1));
        idle_cycles(2);

        // Watchdog expiry with no actual
        cycle(1'b1, 32'h77, 3'd0, 8'd0, 1'b0, 32'd0);
        idle_cycles(TIMEOUT + 3);

        // Actual handshake in the expiry cycle wins
        cycle(1'b1, 32'h33, 3'd0, 8'd0, 1'b0, 32'd0);
        idle_cycles(TIMEOUT - 1);
        cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 32'h33);
        idle_cycles(TIMEOUT + 2);

        // Reset with four entries queued and a result pending
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(i), 3'd0, 8'd0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 32'd0);
        apply_reset();
        idle_cycles(2);

        // Randomized traffic in phases of differing valid densities
        for (int ph = 0; ph < 6; ph++) begin
            int pe, pa;
            pe = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 40 : 90;
            pa = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 90 : 4;
            for (int i = 0; i < 150; i++) begin
                bit ev, av;
                logic [31:0] ed, ad;
                ev   = ($urandom_range(0, 99) < pe);
                av   = ($urandom_range(0, 99) < pa);
                base = ($urandom_range(0, 3) == 0) ? $urandom : 32'd100;
                ed   = base + 32'($urandom_range(0, 12));
                ad   = ($urandom_range(0, 7) == 0) ? $urandom : base + 32'($urandom_range(0, 12));
                cycle(ev, ed, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 6)), av, ad);
            end
        end
        idle_cycles(TIMEOUT * (DEPTH + 1) + 4);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tb_stream_checker.md
# tb_stream_checker

Self-checking stream scoreboard for simulation benches: expected values and a per-entry compare mode are queued in a FIFO. Each actual beat is compared against the head entry and produces a registered pass/fail result. Pass/fail counters and a timeout watchdog extend the single-shot EXPECT_* checks into a parametrised, clocked checker that sits between a DUT output stream and the bench sequencer. It is synthesizable when the display feature is compiled out.

## Interface
- DATA_W, 32, width of expected/actual data (unsigned)
- DEPTH, 8, expected-queue entries (power of two, ≥2)
- TOL_W, 8, width of NEAR tolerance field
- TIMEOUT, 1024, cycles a pending entry may wait for an actual beat; 0 disables watchdog
- CNT_W, 16, width of pass/fail counters

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  queue can accept
- exp_data  in  DATA_W  expected value
- exp_mode  in  3  0 EQ, 1 NE, 2 LE, 3 LT, 4 GE, 5 GT, 6 NEAR, 7 ANY
- exp_tol  in  TOL_W  tolerance for NEAR
- act_valid  in  1  actual beat offered
- act_ready  out  1  checker can consume
- act_data  in  DATA_W  actual value
- res_valid  out  1  one-cycle result strobe
- res_pass  out  1  result of compare
- res_timeout  out  1  result caused by watchdog
- res_actual  out  DATA_W  actual compared (0 on timeout)
- res_expected  out  DATA_W  head expected value
- pass_count  out  CNT_W  saturating pass count
- fail_count  out  CNT_W  saturating fail count (includes timeouts)
- any_fail  out  1  sticky, set on first fail
- idle  out  1  queue empty

## Operation
- FIFO of {data, mode, tol}; occupancy register 0..DEPTH; pointers wrap modulo DEPTH.
- Push on exp_valid && exp_ready; exp_ready = (occupancy < DEPTH); no pass-through when full, even if pop is concurrent.
- Pop on act_valid && act_ready; act_ready = (occupancy > 0). Push and pop in the same cycle: occupancy unchanged.
- Compare (actual vs expected, unsigned): EQ a==e; NE a!=e; LE a<=e; LT a<e; GE a>=e; GT a>e; NEAR |a−e| ≤ tol, with the difference computed at DATA_W+1 bits and tol zero-extended; ANY always passes.
- Watchdog: counter increments each cycle with occupancy>0 and no pop; clears on pop or when empty. On reaching TIMEOUT: force pop of head, res_pass=0, res_timeout=1, counter clears.
- Actual handshake in the watchdog-expiry cycle: the handshake wins and the watchdog does not fire.
- Counters saturate at all-ones. any_fail is cleared only by rst.

## Timing
- Reset values: exp_ready 1, act_ready 0, res_* 0, counters 0, any_fail 0, idle 1, queue empty.
- Result latency 1 cycle: res_valid high the cycle after the pop edge; counters and any_fail update on that same edge.
- exp_ready/act_ready/idle are combinational from registered occupancy only; there is no input-to-ready path.
- Sustained throughput: one compare per cycle.
- Reset mid-operation discards queue contents, pending result and counts immediately.

## Configuration
- TB_STREAM_CHECKER_DISPLAY_EN defined: on every res_valid, $display one line of the form " [PASS] <mode> act=0x.. exp=0x.." or "![FAIL] <mode> act=0x.. exp=0x.."; timeouts print "![FAIL] timeout exp=0x..". Not synthesizable.
- Not defined: no display statements. Identical cycle behaviour, synthesizable.

## Test plan
- Push EQ 0x5A, then act 0x5A → res_valid 1 cycle after pop, res_pass=1, pass_count=1, any_fail=0.
- Push LT 10, GE 10, NEAR 100 tol 3; acts 9, 10, 104 → pass, pass, fail; pass_count=2, fail_count=1, any_fail=1.
- Fill 8 entries → exp_ready=0. Push and pop in the same cycle while full → push refused, occupancy 7.
- TIMEOUT=16, push one entry, no actual → at cycle 16 res_timeout=1, res_pass=0, fail_count=1, idle=1.
- Actual handshake on the expiry cycle → normal compare result, res_timeout=0.
- Assert rst with 4 entries queued and a result pending → all outputs return to reset values next cycle, act_ready=0.
